// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: ALU op codes,
// controller state encoding and a small op-decode helper.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_ADD     = 3'b010,
    OP_ILLEGAL = 3'b011,
    OP_ANDN    = 3'b100,
    OP_ORN     = 3'b101,
    OP_SUB     = 3'b110,
    OP_SLT     = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit MIPS ALU: Alucont[2] inverts B and supplies the carry-in, so
// SUB/ANDN/ORN/SLT reuse the AND/OR/ADD paths. Unused code 011 yields 0.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic [2:0]           alucont,
  output logic [ALU_WIDTH-1:0] result,
  output logic                 zero
);

  logic [ALU_WIDTH-1:0] b_mux;
  logic [ALU_WIDTH-1:0] sum;

  // NOTE: combinational blocks assign every output before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    result = '0;
    b_mux  = alucont[2] ? ~b : b;
    sum    = a + b_mux + {{(ALU_WIDTH-1){1'b0}}, alucont[2]};
    case (alucont)
      OP_AND, OP_ANDN: result = a & b_mux;
      OP_OR,  OP_ORN:  result = a | b_mux;
      OP_ADD, OP_SUB:  result = sum;
      // Sign of A-B only; overflow is deliberately ignored, as in the MIPS ALU.
      OP_SLT:          result = {{(ALU_WIDTH-1){1'b0}}, sum[ALU_WIDTH-1]};
      default:         result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two valid/ready requesters with round-robin
// arbitration; each operation runs IDLE -> EXEC -> RESP and returns on its own channel.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,

  output logic             busy
);

  state_e           state_q,  state_d;
  logic             ptr_q,    ptr_d;
  logic             id_q,     id_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       op_q,     op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             err_q,    err_d;

  logic             gnt_valid;
  logic             gnt_id;
  logic             rsp_ready_sel;
  logic             in_idle;
  logic             rsp0_sel;
  logic             rsp1_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  alu u_alu (
    .a       (a_q),
    .b       (b_q),
    .alucont (op_q),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  end

  assign rsp_ready_sel = id_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d    = gnt_id;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          op_d    = gnt_id ? req1_op : req0_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        err_d    = op_is_illegal(op_q);
        state_d  = RESP;
      end
      RESP: begin
        // Fairness is charged when the result is consumed, not when accepted.
        if (rsp_ready_sel) begin
          ptr_d   = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; all registers here are plain flops and are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= PRIO_INIT;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign in_idle    = (state_q == IDLE);
  assign req0_ready = in_idle && gnt_valid && !gnt_id;
  assign req1_ready = in_idle && gnt_valid &&  gnt_id;
  assign busy       = !in_idle;

  // The non-selected channel is forced to zero rather than showing stale data.
  assign rsp0_sel    = (state_q == RESP) && !id_q;
  assign rsp1_sel    = (state_q == RESP) &&  id_q;
  assign rsp0_valid  = rsp0_sel;
  assign rsp1_valid  = rsp1_sel;
  assign rsp0_result = rsp0_sel ? result_q : '0;
  assign rsp1_result = rsp1_sel ? result_q : '0;
  assign rsp0_zero   = rsp0_sel && zero_q;
  assign rsp1_zero   = rsp1_sel && zero_q;
  assign rsp0_err    = rsp0_sel && err_q;
  assign rsp1_err    = rsp1_sel && err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized self-checking bench for alu_share_ctrl against a
// transaction-level model of arbitration, ALU arithmetic and response timing.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_ptr;

  always #5 clk = ~clk;

  alu_share_ctrl #(.PRIO_INIT(1'b0), .WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_err    (rsp1_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic written straight from the MIPS op definitions.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] diff;
    diff = a - b;
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return diff;
      3'b111:  return {31'd0, diff[31]};
      default: return 32'd0;
    endcase
  endfunction

  // Called on a negedge with the DUT idle; returns on the negedge after the handshake.
  task automatic do_op(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] op0, input bit v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [2:0] op1, input int hold);
    bit          exp_id;
    logic [31:0] exp_res;
    logic [2:0]  exp_op;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    if (!v0 && !v1) begin
      check("idle_ready0", req0_ready, 0);
      check("idle_ready1", req1_ready, 0);
      @(negedge clk);
      check("idle_busy", busy, 0);
      return;
    end
    exp_id  = (v0 && v1) ? model_ptr : v1;
    exp_op  = exp_id ? op1 : op0;
    exp_res = exp_id ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
    check("grant_ready0", req0_ready, exp_id == 1'b0);
    check("grant_ready1", req1_ready, exp_id == 1'b1);
    check("accept_busy", busy, 0);

    @(negedge clk);
    // Scramble operands after accept: the latched copy must be used.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    #1;
    check("exec_busy", busy, 1);
    check("exec_rsp0_valid", rsp0_valid, 0);
    check("exec_rsp1_valid", rsp1_valid, 0);

    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      if (exp_id) rsp1_ready = (h == hold);
      else        rsp0_ready = (h == hold);
      #1;
      check("resp_busy", busy, 1);
      check("resp_req0_ready", req0_ready, 0);
      check("resp_req1_ready", req1_ready, 0);
      check("rsp0_valid", rsp0_valid, exp_id == 1'b0);
      check("rsp1_valid", rsp1_valid, exp_id == 1'b1);
      check("rsp_result", exp_id ? rsp1_result : rsp0_result, exp_res);
      check("rsp_zero", exp_id ? rsp1_zero : rsp0_zero, exp_res == 32'd0);
      check("rsp_err", exp_id ? rsp1_err : rsp0_err, exp_op == 3'b011);
      check("other_result", exp_id ? rsp0_result : rsp1_result, 0);
      check("other_zero_err", exp_id ? {rsp0_zero, rsp0_err} : {rsp1_zero, rsp1_err}, 0);
      @(negedge clk);
    end
    model_ptr = ~exp_id;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("post_hs_busy", busy, 0);
    check("post_hs_valid", {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [2:0]  rop0, rop1;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    model_ptr = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valids", {rsp0_valid, rsp1_valid}, 0);
    check("rst_readies", {req0_ready, req1_ready}, 0);
    check("rst_results", rsp0_result | rsp1_result, 0);
    check("rst_flags", {rsp0_zero, rsp1_zero, rsp0_err, rsp1_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add, then zero flag and SLT on requester 1.
    do_op(1, 32'd5, 32'd7, 3'b010, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 1, 32'd7, 32'd7, 3'b110, 0);
    do_op(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 3'b111, 0);
    // SLT with overflow: 0x80000000 - 1 is positive in wrapped arithmetic.
    do_op(0, 0, 0, 0, 1, 32'h8000_0000, 32'd1, 3'b111, 0);
    // Round-robin with both valid; pointer was left at 0 by requester 1.
    for (int i = 0; i < 4; i++)
      do_op(1, i, 32'd3, 3'b010, 1, 32'd100 + i, 32'd1, 3'b110, 0);
    // Backpressure hold, illegal op, lone requester back-to-back, wrap-around add.
    do_op(1, 32'hDEAD_0000, 32'h0000_BEEF, 3'b001, 0, 0, 0, 0, 4);
    do_op(1, 32'hFF, 32'hF0, 3'b011, 0, 0, 0, 0, 1);
    do_op(1, 32'hFFFF_FFFF, 32'd1, 3'b010, 0, 0, 0, 0, 0);
    do_op(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 0, 0, 0, 0, 0);
    do_op(1, 32'h0, 32'h0F0F_0F0F, 3'b101, 0, 0, 0, 0, 0);
    // Requester drops valid without being served.
    do_op(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while in EXEC drops the operation.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'b010;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valids", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
    end
    do_op(1, 32'd1, 32'd2, 3'b010, 1, 32'd3, 32'd4, 3'b010, 0);

    // Randomized mix, biased toward equal operands and both-valid contention.
    for (int i = 0; i < 60; i++) begin
      ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      rop0 = 3'($urandom_range(0, 7));
      rop1 = 3'($urandom_range(0, 7));
      do_op(bit'($urandom_range(0, 3) != 0), ra0, rb0, rop0,
            bit'($urandom_range(0, 3) != 0), ra1, rb1, rop1,
            $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks made", n_checks);
    $fatal(1);
  end

endmodule
